mcu_spi_bridge: RTL and testbench
=================================

MCU_SPI_BRIDGE -- requirements
Module: mcu_spi_bridge

Interface
REQ-001 SHALL have parameter TARGETS, default 4, meaning the number of addressable MCU targets (ids 0..TARGETS-1).
REQ-002 SHALL provide clk, input, 1, system clock; one clock only, at least 8x the SPI SCLK rate.
REQ-003 SHALL provide reset, input, 1, synchronous active-high reset.
REQ-004 SHALL provide spi_io_ss, input, 1, MCU chip select, active low, asynchronous to clk.
REQ-005 SHALL provide spi_io_clk, input, 1, MCU SCLK, SPI mode 0, MSB first, asynchronous to clk.
REQ-006 SHALL provide spi_io_din, input, 1, MOSI.
REQ-007 SHALL provide spi_io_dout, output, 1, MISO.
REQ-008 SHALL provide mcu_strobe, output, TARGETS, one-hot per-target byte strobe, one clk wide.
REQ-009 SHALL provide mcu_start, output, 1, qualifies mcu_strobe: high = command byte.
REQ-010 SHALL provide mcu_dout, output, 8, received byte, valid while any mcu_strobe bit is high.
REQ-011 SHALL provide mcu_din, input, 8*TARGETS, reply byte per target; slice i belongs to target i.

Function
REQ-012 SHALL pass spi_io_ss, spi_io_clk, spi_io_din through 3-flop synchronizers; SCLK edges are detected on synchronized stages 2/3.
REQ-013 SHALL implement states IDLE, TARGET, COMMAND, DATA.
REQ-014 SHALL go IDLE->TARGET on a synchronized SS falling edge; the bit counter clears to 0.
REQ-015 SHALL sample MOSI on each synchronized SCLK rising edge into an 8-bit shift register, MSB first, with a 3-bit wrapping bit counter.
REQ-016 SHALL, on completion of byte 0 in TARGET, latch it as target id, generate no strobe, and go to COMMAND.
REQ-017 SHALL, on byte completion in COMMAND, pulse mcu_strobe[id] with mcu_start=1 and mcu_dout=byte exactly 1 clk after the 8th rising-edge detection, then go to DATA.
REQ-018 SHALL, on each byte completion in DATA, pulse mcu_strobe[id] with mcu_start=0 under the same timing; remain in DATA.
REQ-019 SHALL generate no strobe for target id >= TARGETS; the frame is still tracked and MISO returns 8'h00.
REQ-020 SHALL return to IDLE on a synchronized SS rising edge from any state; a partial byte is discarded with no strobe.
REQ-021 SHALL load the TX shift register from mcu_din[id] exactly 2 clk after each strobe, giving the target one clk to update its reply.
REQ-022 SHALL shift TX on synchronized SCLK falling edges; spi_io_dout = tx[7].
REQ-023 SHALL, when no load has occurred in the frame (bytes 0 and 1), have TX hold 8'h00.
REQ-024 SHALL drive spi_io_dout 0 in IDLE.
REQ-025 SHALL give mcu_strobe, mcu_start and mcu_dout a registered 0 value whenever no strobe is active.

Reset
REQ-026 SHALL, on reset, set state=IDLE, bit counter=0, shift registers=0, mcu_strobe=0, mcu_start=0, mcu_dout=0, spi_io_dout=0, and synchronizers to SS=1, SCLK=0.
REQ-027 SHALL, on reset asserted mid-frame, accept no further bytes until the next SS falling edge after reset release.

Structure
REQ-028 SHALL place the state enum and target id constants (SYS=0, HID=1, OSD=2, SDC=3) in shared package mcu_spi_pkg.
REQ-029 SHALL implement the 3-flop synchronizer as one sub-module, spi_sync, instantiated once per SPI input.

Verification
REQ-030 SHALL cover a frame of 00,05,A5 at SCLK=clk/10 -> mcu_strobe=0001 with start=1 and dout=05, then strobe=0001 with start=0 and dout=A5; no other strobes.
REQ-031 SHALL cover target 0 with mcu_din[7:0] updated to 5C on the command strobe -> MISO shifts 5C during byte 2.
REQ-032 SHALL cover a frame of 07,01,02 with TARGETS=4 -> no strobes, and MISO reads 00 for all bytes.
REQ-033 SHALL cover SS deasserted after 5 bits of byte 2 -> no third strobe, state IDLE; the next frame 01,03 -> mcu_strobe=0010, start=1, dout=03.
REQ-034 SHALL cover reset pulsed during byte 1, then SCLK continuing without an SS edge -> no strobes until a new SS-low frame.
REQ-035 SHALL cover back-to-back frames with SS high for 4 clk -> both frames decoded independently, with the target id relatched.

Source files
------------

// File: rtl/mcu_spi_pkg.sv
// Shared types and constants for the MCU SPI bridge.
package mcu_spi_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  // Frame position: idle, expecting target id, expecting command, data bytes.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TARGET  = 2'd1,
    COMMAND = 2'd2,
    DATA    = 2'd3
  } state_t;

  // Well-known target ids.
  localparam logic [BYTE_W-1:0] SYS = 8'd0;
  localparam logic [BYTE_W-1:0] HID = 8'd1;
  localparam logic [BYTE_W-1:0] OSD = 8'd2;
  localparam logic [BYTE_W-1:0] SDC = 8'd3;

endpackage

// File: rtl/spi_sync.sv
// Three-flop synchronizer; exposes stages 2 and 3 for edge detection.
module spi_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q2,
  output logic q3
);

  logic q1;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      q1 <= RESET_VAL;
      q2 <= RESET_VAL;
      q3 <= RESET_VAL;
    end else begin
      q1 <= d;
      q2 <= q1;
      q3 <= q2;
    end
  end

endmodule

// File: rtl/mcu_spi_bridge.sv
// SPI slave that routes framed bytes (target, command, data...) to MCU targets.
module mcu_spi_bridge
  import mcu_spi_pkg::*;
#(
  parameter int unsigned TARGETS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_io_ss,
  input  logic                  spi_io_clk,
  input  logic                  spi_io_din,
  output logic                  spi_io_dout,
  output logic [TARGETS-1:0]    mcu_strobe,
  output logic                  mcu_start,
  output logic [BYTE_W-1:0]     mcu_dout,
  input  logic [8*TARGETS-1:0]  mcu_din
);

  logic ss_q2, ss_q3, sck_q2, sck_q3, din_q2, din_unused;

  spi_sync #(.RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset(reset), .d(spi_io_ss), .q2(ss_q2), .q3(ss_q3)
  );
  spi_sync #(.RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .reset(reset), .d(spi_io_clk), .q2(sck_q2), .q3(sck_q3)
  );
  spi_sync #(.RESET_VAL(1'b0)) u_sync_din (
    .clk(clk), .reset(reset), .d(spi_io_din), .q2(din_q2), .q3(din_unused)
  );

  logic ss_fall, ss_rise, sck_rise, sck_fall;
  assign ss_fall  = ~ss_q2 &  ss_q3;
  assign ss_rise  =  ss_q2 & ~ss_q3;
  assign sck_rise =  sck_q2 & ~sck_q3;
  assign sck_fall = ~sck_q2 &  sck_q3;

  state_t              state, state_next;
  logic [CNT_W-1:0]    bit_cnt;
  logic [BYTE_W-1:0]   rx_shift, tx_shift, target_id;
  logic [1:0]          flush_cnt;
  logic                armed, load_pend;

  logic                byte_done, target_valid, frame_clear;
  logic [BYTE_W-1:0]   rx_byte, reply;
  logic [TARGETS-1:0]  strobe_nxt;
  logic                start_nxt;
  logic [BYTE_W-1:0]   dout_nxt;

  assign rx_byte      = {rx_shift[BYTE_W-2:0], din_q2};
  assign byte_done    = (state != IDLE) && sck_rise && (bit_cnt == 3'd7) && !ss_rise;
  assign target_valid = (target_id < 8'(TARGETS));
  assign frame_clear  = (state == IDLE) || (state_next == IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and strobe decode for the byte being completed.
  always_comb begin
    state_next = state;
    strobe_nxt = '0;
    start_nxt  = 1'b0;
    dout_nxt   = '0;
    reply      = '0;
    case (state)
      IDLE:    if (ss_fall && armed) state_next = TARGET;
      TARGET:  if (byte_done) state_next = COMMAND;
      COMMAND: if (byte_done) state_next = DATA;
      DATA:    state_next = DATA;
      default: state_next = IDLE;
    endcase
    if (ss_rise) state_next = IDLE;

    for (int i = 0; i < int'(TARGETS); i++) begin
      if (target_id == 8'(i)) reply = mcu_din[8*i +: 8];
    end

    if (byte_done && target_valid && (state == COMMAND || state == DATA)) begin
      for (int i = 0; i < int'(TARGETS); i++) begin
        strobe_nxt[i] = (target_id == 8'(i));
      end
      start_nxt = (state == COMMAND);
      dout_nxt  = rx_byte;
    end
  end

  // Datapath: receive/transmit shift registers, counters and MCU outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      target_id  <= '0;
      flush_cnt  <= '0;
      armed      <= 1'b0;
      load_pend  <= 1'b0;
      mcu_strobe <= '0;
      mcu_start  <= 1'b0;
      mcu_dout   <= '0;
    end else begin
      // Ignore SS until the synchronizer holds real pin values and SS is seen high.
      if (flush_cnt != 2'd3) flush_cnt <= flush_cnt + 2'd1;
      else if (ss_q3)        armed     <= 1'b1;

      mcu_strobe <= strobe_nxt;
      mcu_start  <= start_nxt;
      mcu_dout   <= dout_nxt;
      load_pend  <= |mcu_strobe;

      if (frame_clear) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (sck_rise) begin
        rx_shift <= rx_byte;
        bit_cnt  <= bit_cnt + 3'd1;
      end

      if (state == TARGET && byte_done) target_id <= rx_byte;

      // Byte-boundary falling edge (count wrapped to 0) must not shift out the new MSB.
      if (frame_clear)                      tx_shift <= '0;
      else if (load_pend)                   tx_shift <= reply;
      else if (sck_fall && bit_cnt != 3'd0) tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
    end
  end

  assign spi_io_dout = tx_shift[BYTE_W-1];

endmodule

// File: tb/tb_mcu_spi_bridge.sv
// Directed bench for mcu_spi_bridge with a strobe scoreboard and MISO checks.
module tb_mcu_spi_bridge;
  import mcu_spi_pkg::*;

  localparam int unsigned TGT = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             spi_io_ss, spi_io_clk, spi_io_din, spi_io_dout;
  logic [TGT-1:0]   mcu_strobe;
  logic             mcu_start;
  logic [7:0]       mcu_dout;
  logic [8*TGT-1:0] mcu_din;
  logic [7:0]       din0;

  typedef struct packed {
    logic [TGT-1:0] strobe;
    logic           start;
    logic [7:0]     dout;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mcu_spi_bridge #(.TARGETS(TGT)) dut (
    .clk(clk), .reset(reset),
    .spi_io_ss(spi_io_ss), .spi_io_clk(spi_io_clk), .spi_io_din(spi_io_din),
    .spi_io_dout(spi_io_dout),
    .mcu_strobe(mcu_strobe), .mcu_start(mcu_start), .mcu_dout(mcu_dout),
    .mcu_din(mcu_din)
  );

  always #5 clk = ~clk;

  // Target 0 model: updates its reply on a command strobe.
  always @(posedge clk) begin
    if (reset) din0 <= 8'h11;
    else if (mcu_strobe[0] && mcu_start) din0 <= 8'h5C;
  end
  assign mcu_din = {8'h77, 8'h66, 8'h3C, din0};

  // Strobe monitor: pop scoreboard on each strobe, require quiet outputs otherwise.
  always @(negedge clk) begin
    exp_t obs, ex;
    if (!reset) begin
      obs = {mcu_strobe, mcu_start, mcu_dout};
      if (mcu_strobe != '0) begin
        ex = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        checks++;
        assert (obs === ex)
          else begin errors++; $error("FAIL strobe obs=%h exp=%h", obs, ex); end
      end else begin
        checks++;
        assert (obs === '0)
          else begin errors++; $error("FAIL quiet obs=%h exp=0", obs); end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_xfer(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
    miso = '0;
    for (int b = 0; b < nbits; b++) begin
      spi_io_din = mosi[7-b];
      wait_clk(5);
      miso = {miso[6:0], spi_io_dout};
      spi_io_clk = 1'b1;
      wait_clk(5);
      spi_io_clk = 1'b0;
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] ex);
    checks++;
    assert (obs === ex)
      else begin errors++; $error("FAIL %s obs=%h exp=%h", tag, obs, ex); end
  endtask

  task automatic push(input logic [TGT-1:0] s, input logic st, input logic [7:0] d);
    exp_t e;
    e = {s, st, d};
    exp_q.push_back(e);
  endtask

  initial begin
    logic [7:0] rx;
    reset = 1'b1; spi_io_ss = 1'b1; spi_io_clk = 1'b0; spi_io_din = 1'b0;
    wait_clk(4);
    check8("rst_strobe", 8'(mcu_strobe), 8'h00);
    check8("rst_start",  8'(mcu_start),  8'h00);
    check8("rst_dout",   mcu_dout,       8'h00);
    check8("rst_miso",   8'(spi_io_dout), 8'h00);
    check8("rst_state",  8'(dut.state),  8'(IDLE));
    reset = 1'b0;
    wait_clk(10);

    // Frame 00,05,A5: command and data strobes to target 0; reply 5C in byte 2.
    push(4'b0001, 1'b1, 8'h05);
    push(4'b0001, 1'b0, 8'hA5);
    spi_io_ss = 1'b0; wait_clk(6);
    spi_xfer(8'h00, 8, rx); check8("f1_miso0", rx, 8'h00);
    spi_xfer(8'h05, 8, rx); check8("f1_miso1", rx, 8'h00);
    spi_xfer(8'hA5, 8, rx); check8("f1_miso2", rx, 8'h5C);
    wait_clk(6); spi_io_ss = 1'b1; wait_clk(10);

    // Frame 07,01,02: invalid target, no strobes, MISO zero.
    spi_io_ss = 1'b0; wait_clk(6);
    spi_xfer(8'h07, 8, rx); check8("f2_miso0", rx, 8'h00);
    spi_xfer(8'h01, 8, rx); check8("f2_miso1", rx, 8'h00);
    spi_xfer(8'h02, 8, rx); check8("f2_miso2", rx, 8'h00);
    wait_clk(6); spi_io_ss = 1'b1; wait_clk(10);

    // Frame 01,03 then 5 bits of byte 2 and SS release: partial byte dropped.
    push(4'b0010, 1'b1, 8'h03);
    spi_io_ss = 1'b0; wait_clk(6);
    spi_xfer(8'h01, 8, rx);
    spi_xfer(8'h03, 8, rx);
    spi_xfer(8'hFF, 5, rx);
    wait_clk(6); spi_io_ss = 1'b1; wait_clk(8);
    check8("part_state", 8'(dut.state), 8'(IDLE));
    wait_clk(4);
    push(4'b0010, 1'b1, 8'h03);
    spi_io_ss = 1'b0; wait_clk(6);
    spi_xfer(8'h01, 8, rx);
    spi_xfer(8'h03, 8, rx);
    wait_clk(6); spi_io_ss = 1'b1; wait_clk(10);

    // Reset during byte 1 with SS still low: no bytes accepted afterwards.
    spi_io_ss = 1'b0; wait_clk(6);
    spi_xfer(8'h00, 8, rx);
    spi_xfer(8'h09, 4, rx);
    reset = 1'b1; wait_clk(2);
    check8("mid_rst_state",  8'(dut.state), 8'(IDLE));
    check8("mid_rst_strobe", 8'(mcu_strobe), 8'h00);
    reset = 1'b0;
    spi_xfer(8'h09, 4, rx);
    spi_xfer(8'h12, 8, rx);
    spi_xfer(8'h34, 8, rx);
    check8("mid_rst_idle", 8'(dut.state), 8'(IDLE));
    wait_clk(6); spi_io_ss = 1'b1; wait_clk(10);
    push(4'b0100, 1'b1, 8'h09);
    spi_io_ss = 1'b0; wait_clk(6);
    spi_xfer(8'h02, 8, rx);
    spi_xfer(8'h09, 8, rx); check8("post_rst_miso1", rx, 8'h00);
    wait_clk(6); spi_io_ss = 1'b1; wait_clk(10);

    // Back-to-back frames separated by 4 clk of SS high; target relatched.
    push(4'b0010, 1'b1, 8'h0A);
    push(4'b0010, 1'b0, 8'h0B);
    push(4'b1000, 1'b1, 8'h0C);
    spi_io_ss = 1'b0; wait_clk(6);
    spi_xfer(8'h01, 8, rx);
    spi_xfer(8'h0A, 8, rx);
    spi_xfer(8'h0B, 8, rx); check8("b2b_miso_t1", rx, 8'h3C);
    wait_clk(6); spi_io_ss = 1'b1; wait_clk(4);
    spi_io_ss = 1'b0; wait_clk(6);
    spi_xfer(8'h03, 8, rx);
    spi_xfer(8'h0C, 8, rx); check8("b2b_miso_t3", rx, 8'h00);
    wait_clk(6); spi_io_ss = 1'b1; wait_clk(20);

    check8("sb_empty", 8'(exp_q.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
